// File: rtl/sift_keypoint_collector_if.sv
`default_nettype none
// ============================================================================
// Module   : sift_keypoint_collector_if
// Purpose  : Keypoint record stream (valid/ready) from the collector FIFO to
//            the descriptor stage.
// Revision : 1.0  initial release
// ============================================================================
interface sift_keypoint_collector_if #(
  parameter int DW = 21
);
  logic          kp_valid;
  logic          kp_ready;
  logic [DW-1:0] kp_data;

  modport master (output kp_valid, output kp_data, input kp_ready);
  modport slave  (input kp_valid, input kp_data, output kp_ready);
endinterface
`default_nettype wire

// File: rtl/sift_keypoint_collector.sv
`default_nettype none
// ============================================================================
// Module   : sift_keypoint_collector
// Purpose  : Consumes the extrema detector's per-pixel type stream, skips the
//            window warm-up samples, rebuilds the (x, y) of each window
//            centre, rejects border hits and queues accepted minima/maxima as
//            {type, y, x} records in a small FIFO drained by valid/ready.
// Revision : 1.0  initial release
// ============================================================================
module sift_keypoint_collector #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int XW           = 10,
  parameter int YW           = 9,
  parameter int LAT          = 642,
  parameter int BORDER       = 1,
  parameter int FIFO_DEPTH   = 16,
  parameter int CNT_W        = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      frame_start,
  input  logic [2:0]                ext_type,
  sift_keypoint_collector_if.master kp,
  output logic                      kp_overflow,
  output logic [CNT_W-1:0]          kp_count,
  output logic                      frame_done,
  output logic                      busy
);

  localparam int c_DW  = 2 + YW + XW;
  localparam int c_AW  = $clog2(FIFO_DEPTH);
  localparam int c_SKW = (LAT < 2) ? 1 : $clog2(LAT + 1);

  localparam logic [c_SKW-1:0] c_SKIP_LAST = c_SKW'((LAT > 0) ? LAT - 1 : 0);
  localparam logic [XW-1:0]    c_X_LAST    = XW'(FRAME_WIDTH - 1);
  localparam logic [YW-1:0]    c_Y_LAST    = YW'(FRAME_HEIGHT - 1);
  localparam logic [XW-1:0]    c_X_LO      = XW'(BORDER);
  localparam logic [XW-1:0]    c_X_HI      = XW'(FRAME_WIDTH - BORDER);
  localparam logic [YW-1:0]    c_Y_LO      = YW'(BORDER);
  localparam logic [YW-1:0]    c_Y_HI      = YW'(FRAME_HEIGHT - BORDER);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_SCAN   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             r_state;
  logic [c_SKW-1:0]   r_skip;
  logic [XW-1:0]      r_x;
  logic [YW-1:0]      r_y;

  logic [c_DW-1:0]    r_mem [FIFO_DEPTH];
  logic [c_AW:0]      r_wptr;
  logic [c_AW:0]      r_rptr;

  logic               w_is_ext;
  logic               w_in_border;
  logic               w_accept;
  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic [c_DW-1:0]    w_rec;

  // Only min (1) and max (2) are keypoints; every other code means "none".
  assign w_is_ext    = (ext_type == 3'd1) || (ext_type == 3'd2);
  assign w_in_border = (r_x >= c_X_LO) && (r_x < c_X_HI) &&
                       (r_y >= c_Y_LO) && (r_y < c_Y_HI);
  // A restart cycle ignores en, so it can never accept a sample.
  assign w_accept    = (r_state == S_SCAN) && en && !frame_start &&
                       w_is_ext && w_in_border;
  assign w_rec       = {ext_type[1:0], r_y, r_x};

  // Extra pointer MSB distinguishes full from empty.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                   (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
  assign w_pop   = !w_empty && kp.kp_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign w_push  = w_accept && (!w_full || w_pop);

  assign kp.kp_valid = !w_empty;
  assign kp.kp_data  = r_mem[r_rptr[c_AW-1:0]];

  // Frame sequencer: warm-up skip, raster position, done pulse and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_skip     <= '0;
      r_x        <= '0;
      r_y        <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (frame_start) begin
        r_skip  <= '0;
        r_x     <= '0;
        r_y     <= '0;
        busy    <= 1'b1;
        r_state <= (LAT == 0) ? S_SCAN : S_WARMUP;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_IDLE;
          end
          S_WARMUP: begin
            if (en) begin
              if (r_skip == c_SKIP_LAST) begin
                r_state <= S_SCAN;
                r_x     <= '0;
                r_y     <= '0;
              end else begin
                r_skip <= r_skip + c_SKW'(1);
              end
            end
          end
          S_SCAN: begin
            if (en) begin
              if (r_x == c_X_LAST) begin
                r_x <= '0;
                if (r_y == c_Y_LAST) begin
                  r_state    <= S_DONE;
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
                end else begin
                  r_y <= r_y + YW'(1);
                end
              end else begin
                r_x <= r_x + XW'(1);
              end
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

  // Per-frame statistics: saturating push count and sticky drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kp_count    <= '0;
      kp_overflow <= 1'b0;
    end else if (frame_start) begin
      kp_count    <= '0;
      kp_overflow <= 1'b0;
    end else begin
      if (w_push && (kp_count != {CNT_W{1'b1}})) begin
        kp_count <= kp_count + CNT_W'(1);
      end
      if (w_accept && !w_push) begin
        kp_overflow <= 1'b1;
      end
    end
  end

  // Keypoint FIFO; storage is cleared on reset so the head reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wptr[c_AW-1:0]] <= w_rec;
        r_wptr                  <= r_wptr + (c_AW+1)'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + (c_AW+1)'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sift_keypoint_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_sift_keypoint_collector
// Purpose  : Self-checking bench for sift_keypoint_collector on a small 8x6
//            frame, compared every cycle against a sample-index/queue model.
// Revision : 1.0  initial release
// ============================================================================
module tb_sift_keypoint_collector;

  localparam int W   = 8;
  localparam int H   = 6;
  localparam int L   = 10;
  localparam int B   = 1;
  localparam int D   = 4;
  localparam int XW  = 3;
  localparam int YW  = 3;
  localparam int CW  = 12;
  localparam int DW  = 2 + YW + XW;
  localparam int NPX = W * H;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          frame_start;
  logic [2:0]    ext_type;
  logic          kp_overflow;
  logic [CW-1:0] kp_count;
  logic          frame_done;
  logic          busy;

  sift_keypoint_collector_if #(.DW(DW)) kif ();

  sift_keypoint_collector #(
    .FRAME_WIDTH (W),
    .FRAME_HEIGHT(H),
    .XW          (XW),
    .YW          (YW),
    .LAT         (L),
    .BORDER      (B),
    .FIFO_DEPTH  (D),
    .CNT_W       (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .frame_start(frame_start),
    .ext_type   (ext_type),
    .kp         (kif.master),
    .kp_overflow(kp_overflow),
    .kp_count   (kp_count),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: frame progress counted in en samples since frame_start,
  // FIFO held as a plain queue of records.
  int            m_k;
  bit            m_active;
  bit            m_done;
  int            m_cnt;
  bit            m_ovf;
  logic [DW-1:0] m_q[$];

  logic [DW-1:0] pops[$];
  logic [2:0]    pat[NPX];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic mdl_reset();
    m_q.delete();
    m_k      = 0;
    m_active = 0;
    m_done   = 0;
    m_cnt    = 0;
    m_ovf    = 0;
  endtask

  task automatic mdl_edge(input bit fs, input bit e, input logic [2:0] t, input bit r);
    bit            pop;
    bit            acc;
    int            p;
    int            x;
    int            y;
    logic [DW-1:0] rec;
    pop    = (m_q.size() > 0) && r;
    acc    = 0;
    rec    = '0;
    m_done = 0;
    if (fs) begin
      m_active = 1;
      m_k      = 0;
      m_cnt    = 0;
      m_ovf    = 0;
    end else if (m_active && e) begin
      if (m_k >= L) begin
        p = m_k - L;
        x = p % W;
        y = p / W;
        if ((t == 3'd1 || t == 3'd2) && x >= B && x < W - B && y >= B && y < H - B) begin
          acc = 1;
          rec = {t[1:0], 3'(y), 3'(x)};
        end
        if (p == NPX - 1) begin
          m_active = 0;
          m_done   = 1;
        end
      end
      m_k++;
    end
    if (pop) void'(m_q.pop_front());
    if (acc) begin
      if (m_q.size() < D) begin
        m_q.push_back(rec);
        if (m_cnt < (1 << CW) - 1) m_cnt++;
      end else begin
        m_ovf = 1;
      end
    end
  endtask

  task automatic compare();
    chk("valid", 32'(kif.kp_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) chk("data", 32'(kif.kp_data), 32'(m_q[0]));
    chk("count", 32'(kp_count), 32'(m_cnt));
    chk("ovf", 32'(kp_overflow), 32'(m_ovf));
    chk("done", 32'(frame_done), 32'(m_done));
    chk("busy", 32'(busy), 32'(m_active));
  endtask

  // One clock: drive inputs, log a handshake, advance model, check outputs.
  task automatic step(input bit fs, input bit e, input logic [2:0] t, input bit r);
    frame_start   = fs;
    en            = e;
    ext_type      = t;
    kif.kp_ready  = r;
    #1;
    if (kif.kp_valid && r) pops.push_back(kif.kp_data);
    @(posedge clk);
    mdl_edge(fs, e, t, r);
    #1;
    compare();
  endtask

  function automatic bit rdy_of(input int m, input int p);
    case (m)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return 1'($urandom_range(0, 1));
      default: return (p >= W + 5);
    endcase
  endfunction

  // gmode: 0 continuous en, 1 alternating en, 2 random gaps.
  // rmode: 0 ready, 1 stalled, 2 random, 3 ready from (5,1) on.
  task automatic run_frame(input int gmode, input int rmode);
    logic [2:0] t;
    step(1'b1, 1'($urandom_range(0, 1)), 3'($urandom), rdy_of(rmode, -1));
    for (int i = 0; i < L + NPX; i++) begin
      t = (i < L) ? 3'($urandom) : pat[i - L];
      if (gmode == 2) begin
        while ($urandom_range(0, 9) < 3) step(1'b0, 1'b0, 3'($urandom), rdy_of(rmode, i - L));
      end
      step(1'b0, 1'b1, t, rdy_of(rmode, i - L));
      if (gmode == 1) step(1'b0, 1'b0, 3'($urandom), rdy_of(rmode, i - L));
    end
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'($urandom), r);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    mdl_reset();
    chk("rst_valid", 32'(kif.kp_valid), 32'd0);
    chk("rst_data", 32'(kif.kp_data), 32'd0);
    chk("rst_count", 32'(kp_count), 32'd0);
    chk("rst_ovf", 32'(kp_overflow), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] rec_a[$];
    int            cnt_a;
    rst_n        = 1'b0;
    en           = 1'b0;
    frame_start  = 1'b0;
    ext_type     = 3'd0;
    kif.kp_ready = 1'b1;
    mdl_reset();
    repeat (3) @(posedge clk);
    #1;
    apply_reset();

    // Warm-up alignment: only the interior max/min at (3,2) survives.
    foreach (pat[i]) pat[i] = 3'd0;
    pat[0]  = 3'd2;
    pat[19] = 3'd1;
    pops.delete();
    run_frame(0, 0);
    idle(3, 1'b1);
    chk("s1_npop", 32'(pops.size()), 32'd1);
    chk("s1_rec", 32'((pops.size() > 0) ? pops[0] : '1), 32'({2'd1, 3'd2, 3'd3}));
    chk("s1_cnt", 32'(kp_count), 32'd1);

    // Interior and border: every interior pixel exactly once in raster order.
    foreach (pat[i]) pat[i] = 3'd1;
    pops.delete();
    run_frame(0, 0);
    idle(3, 1'b1);
    chk("s2_npop", 32'(pops.size()), 32'd24);
    for (int j = 0; j < 24 && j < pops.size(); j++) begin
      chk("s2_rec", 32'(pops[j]), 32'({2'd1, 3'(1 + j / 6), 3'(1 + j % 6)}));
    end

    // Backpressure and overflow.
    pops.delete();
    run_frame(0, 1);
    chk("s3_cnt", 32'(kp_count), 32'd4);
    chk("s3_ovf", 32'(kp_overflow), 32'd1);
    chk("s3_valid", 32'(kif.kp_valid), 32'd1);
    idle(6, 1'b1);
    chk("s3_npop", 32'(pops.size()), 32'd4);
    for (int j = 0; j < 4 && j < pops.size(); j++) begin
      chk("s3_rec", 32'(pops[j]), 32'({2'd1, 3'd1, 3'(1 + j)}));
    end
    chk("s3_empty", 32'(kif.kp_valid), 32'd0);

    // Full with a simultaneous pop: the fifth push at (5,1) must land.
    foreach (pat[i]) pat[i] = (i >= 9 && i <= 13) ? 3'd1 : 3'd0;
    run_frame(0, 3);
    idle(6, 1'b1);
    chk("s4_ovf", 32'(kp_overflow), 32'd0);
    chk("s4_cnt", 32'(kp_count), 32'd5);

    // Mid-frame restart at (3,2) with two records queued.
    pops.delete();
    step(1'b1, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < L + 2 * W + 3; i++) begin
      step(1'b0, 1'b1, (i == L + 9 || i == L + 10) ? 3'd1 : 3'd0, 1'b0);
    end
    step(1'b1, 1'b1, 3'd1, 1'b0);
    chk("s5_cnt", 32'(kp_count), 32'd0);
    chk("s5_ovf", 32'(kp_overflow), 32'd0);
    chk("s5_busy", 32'(busy), 32'd1);
    for (int i = 0; i < L + NPX; i++) begin
      step(1'b0, 1'b1, (i == L + 9) ? 3'd2 : 3'd0, 1'b1);
    end
    idle(3, 1'b1);
    chk("s5_npop", 32'(pops.size()), 32'd3);
    chk("s5_rec2", 32'((pops.size() > 2) ? pops[2] : '1), 32'({2'd2, 3'd1, 3'd1}));

    // en gaps must not change coordinates or counts.
    foreach (pat[i]) pat[i] = 3'($urandom);
    pops.delete();
    run_frame(0, 0);
    cnt_a = int'(kp_count);
    idle(3, 1'b1);
    rec_a = pops;
    pops.delete();
    run_frame(1, 0);
    chk("s6_cnt", 32'(kp_count), 32'(cnt_a));
    idle(3, 1'b1);
    chk("s6_npop", 32'(pops.size()), 32'(rec_a.size()));
    for (int j = 0; j < rec_a.size() && j < pops.size(); j++) begin
      chk("s6_rec", 32'(pops[j]), 32'(rec_a[j]));
    end

    // Asynchronous reset mid-frame with records pending.
    foreach (pat[i]) pat[i] = 3'd1;
    step(1'b1, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < L + 20; i++) step(1'b0, 1'b1, 3'd1, 1'b0);
    apply_reset();
    idle(2, 1'b1);

    // Randomized frames: random types, gaps and backpressure.
    for (int f = 0; f < 6; f++) begin
      foreach (pat[i]) pat[i] = 3'($urandom);
      run_frame(2, 2);
      idle(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end
    idle(8, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
